// File: rtl/rv_bridge_pkg.sv
// Shared types and constants for the RISC-V to SDRAM RV-channel bridge.
package rv_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LO,
    HI,
    ACK
  } state_e;

  localparam logic       HALF_LO   = 1'b0;
  localparam logic       HALF_HI   = 1'b1;
  localparam logic [1:0] RD_DS_ALL = 2'b11;

endpackage

// File: rtl/clkref_slot_tick.sv
// Two-flop clkref pipeline; bnd_o pulses one clk after the controller sees a rising clkref.
module clkref_slot_tick (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clkref_i,
  output logic bnd_o
);

  logic clkref_r_q;
  logic clkref_rr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clkref_r_q  <= 1'b0;
      clkref_rr_q <= 1'b0;
    end else begin
      clkref_r_q  <= clkref_i;
      clkref_rr_q <= clkref_r_q;
    end
  end

  assign bnd_o = clkref_r_q & ~clkref_rr_q;

endmodule

// File: rtl/rv_sdram_bridge.sv
// Splits 32-bit core accesses into slot-aligned 16-bit RV-channel accesses.
// Define RV_RDBUF_EN to add a one-entry read buffer that serves repeated reads without SDRAM access.
module rv_sdram_bridge
  import rv_bridge_pkg::*;
#(
  parameter int STALL_W = 16,
  parameter int ADDR_W  = 21
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clkref,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_wstrb,
  output logic [31:0]        mem_rdata,
  output logic [ADDR_W:0]    rv_addr,
  output logic [15:0]        rv_din,
  output logic [1:0]         rv_ds,
  output logic               rv_rd,
  output logic               rv_wr,
  input  logic               rv_wait,
  input  logic [15:0]        rv_dout,
  output logic [STALL_W-1:0] stall_slots
);

  logic bnd;

  clkref_slot_tick u_tick (
    .clk_i    (clk),
    .rst_i    (reset),
    .clkref_i (clkref),
    .bnd_o    (bnd)
  );

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               abort_q, abort_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [ADDR_W:0]    rv_addr_q, rv_addr_d;
  logic [15:0]        rv_din_q, rv_din_d;
  logic [1:0]         rv_ds_q, rv_ds_d;
  logic               rv_rd_q, rv_rd_d;
  logic               rv_wr_q, rv_wr_d;
  logic [STALL_W-1:0] stall_q, stall_d;
`ifdef RV_RDBUF_EN
  logic               buf_vld_q, buf_vld_d;
  logic [ADDR_W-1:0]  buf_addr_q, buf_addr_d;
  logic [31:0]        buf_data_q, buf_data_d;
`endif

  logic       is_rd;
  logic       need_lo;
  logic       need_hi;
  logic [1:0] ds_lo;
  logic [1:0] ds_hi;

  assign is_rd   = (wstrb_q == 4'b0000);
  assign need_lo = is_rd | (|wstrb_q[1:0]);
  assign need_hi = is_rd | (|wstrb_q[3:2]);
  assign ds_lo   = is_rd ? RD_DS_ALL : wstrb_q[1:0];
  assign ds_hi   = is_rd ? RD_DS_ALL : wstrb_q[3:2];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    abort_d   = abort_q;
    rdata_d   = rdata_q;
    rv_addr_d = rv_addr_q;
    rv_din_d  = rv_din_q;
    rv_ds_d   = rv_ds_q;
    rv_rd_d   = rv_rd_q;
    rv_wr_d   = rv_wr_q;
    stall_d   = stall_q;
`ifdef RV_RDBUF_EN
    buf_vld_d  = buf_vld_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
`endif

    // A core that drops mem_valid mid-access still gets the access finished, but no ready.
    if ((state_q == ARM || state_q == LO || state_q == HI) && !mem_valid) begin
      abort_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          abort_d = 1'b0;
          state_d = ARM;
`ifdef RV_RDBUF_EN
          if (mem_wstrb == 4'b0000 && buf_vld_q && buf_addr_q == mem_addr) begin
            rdata_d = buf_data_q;
            state_d = ACK;
          end
          if (mem_wstrb != 4'b0000 && buf_addr_q == mem_addr) begin
            buf_vld_d = 1'b0;
          end
`endif
        end
      end
      ARM: begin
        if (bnd) begin
          rv_rd_d = is_rd;
          rv_wr_d = ~is_rd;
          if (need_lo) begin
            rv_addr_d = {addr_q, HALF_LO};
            rv_ds_d   = ds_lo;
            if (!is_rd) rv_din_d = wdata_q[15:0];
            state_d = LO;
          end else begin
            rv_addr_d = {addr_q, HALF_HI};
            rv_ds_d   = ds_hi;
            if (!is_rd) rv_din_d = wdata_q[31:16];
            state_d = HI;
          end
        end
      end
      LO: begin
        if (bnd) begin
          if (rv_wait) begin
            if (stall_q != {STALL_W{1'b1}}) stall_d = stall_q + STALL_W'(1);
          end else begin
            if (is_rd) rdata_d[15:0] = rv_dout;
            if (need_hi) begin
              rv_addr_d = {addr_q, HALF_HI};
              rv_ds_d   = ds_hi;
              if (!is_rd) rv_din_d = wdata_q[31:16];
              state_d = HI;
            end else begin
              rv_rd_d = 1'b0;
              rv_wr_d = 1'b0;
              state_d = ACK;
            end
          end
        end
      end
      HI: begin
        if (bnd) begin
          if (rv_wait) begin
            if (stall_q != {STALL_W{1'b1}}) stall_d = stall_q + STALL_W'(1);
          end else begin
            if (is_rd) begin
              rdata_d[31:16] = rv_dout;
`ifdef RV_RDBUF_EN
              buf_vld_d  = 1'b1;
              buf_addr_d = addr_q;
              buf_data_d = {rv_dout, rdata_q[15:0]};
`endif
            end
            rv_rd_d = 1'b0;
            rv_wr_d = 1'b0;
            state_d = ACK;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      abort_q   <= 1'b0;
      rdata_q   <= '0;
      rv_addr_q <= '0;
      rv_din_q  <= '0;
      rv_ds_q   <= '0;
      rv_rd_q   <= 1'b0;
      rv_wr_q   <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      abort_q   <= abort_d;
      rdata_q   <= rdata_d;
      rv_addr_q <= rv_addr_d;
      rv_din_q  <= rv_din_d;
      rv_ds_q   <= rv_ds_d;
      rv_rd_q   <= rv_rd_d;
      rv_wr_q   <= rv_wr_d;
      stall_q   <= stall_d;
    end
  end

`ifdef RV_RDBUF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
  end
`endif

  assign mem_ready   = (state_q == ACK) && !abort_q;
  assign mem_rdata   = rdata_q;
  assign rv_addr     = rv_addr_q;
  assign rv_din      = rv_din_q;
  assign rv_ds       = rv_ds_q;
  assign rv_rd       = rv_rd_q;
  assign rv_wr       = rv_wr_q;
  assign stall_slots = stall_q;

endmodule
